// File: rtl/prbs_checker_if.sv
// Beat stream from a PRBS source into the checker, plus the checker's status and counters.
// The sender drives through the master modport; the checker sits on the slave modport.
interface prbs_checker_if #(
  parameter int LfsrWidth = 16,
  parameter int CntWidth  = 16
) ();
  logic                 valid_i;
  logic [LfsrWidth-1:0] data_i;
  logic                 clr_i;
  logic                 locked_o;
  logic                 err_o;
  logic [CntWidth-1:0]  beat_cnt_o;
  logic [CntWidth-1:0]  err_cnt_o;

  modport master (
    output valid_i, data_i, clr_i,
    input  locked_o, err_o, beat_cnt_o, err_cnt_o
  );

  modport slave (
    input  valid_i, data_i, clr_i,
    output locked_o, err_o, beat_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/prbs_checker.sv
// Galois-LFSR PRBS checker: seeds from the received stream, locks after a run of matches,
// then free-runs its own LFSR so a corrupted word counts as a single error.
module prbs_checker #(
  parameter int                   LfsrWidth = 16,
  parameter logic [LfsrWidth-1:0] Mask      = 16'h8679,
  parameter int                   LockCount = 4,
  parameter int                   LossCount = 4,
  parameter int                   CntWidth  = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  prbs_checker_if.slave bus
);

  localparam int MatchW = $clog2(LockCount + 1);
  localparam int MissW  = $clog2(LossCount + 1);

  typedef enum logic [1:0] {SEEK, ACQ, LOCKED} state_e;

  state_e                state_reg, state_next;
  logic [LfsrWidth-1:0]  exp_reg, exp_next;
  logic [MatchW-1:0]     match_reg, match_next;
  logic [MissW-1:0]      miss_reg, miss_next;
  logic                  err_reg, err_next;
  logic [CntWidth-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CntWidth-1:0]   err_cnt_reg, err_cnt_next;

  // Index 0 steps the received word (seeding), index 1 steps the local expectation.
  logic [1:0][LfsrWidth-1:0] step_src;
  logic [1:0][LfsrWidth-1:0] step_dst;

  assign step_src[0] = bus.data_i;
  assign step_src[1] = exp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_step
      assign step_dst[gi] = (step_src[gi] >> 1) ^ (step_src[gi][0] ? Mask : '0);
    end
  endgenerate

  logic data_nz;
  logic data_match;
  logic lock_hit;
  logic loss_hit;

  assign data_nz    = (bus.data_i != '0);
  assign data_match = (bus.data_i == exp_reg);
  assign lock_hit   = (int'(match_reg) + 1 >= LockCount);
  assign loss_hit   = (int'(miss_reg) + 1 >= LossCount);

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= SEEK;
      exp_reg      <= '0;
      match_reg    <= '0;
      miss_reg     <= '0;
      err_reg      <= 1'b0;
      beat_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      exp_reg      <= exp_next;
      match_reg    <= match_next;
      miss_reg     <= miss_next;
      err_reg      <= err_next;
      beat_cnt_reg <= beat_cnt_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (bus.valid_i) begin
      unique case (state_reg)
        SEEK: begin
          if (data_nz) state_next = ACQ;
        end
        ACQ: begin
          if (data_match) begin
            if (lock_hit) state_next = LOCKED;
          end else if (!data_nz) begin
            state_next = SEEK;
          end
        end
        LOCKED: begin
          if (!data_match && loss_hit) state_next = SEEK;
        end
        default: state_next = SEEK;
      endcase
    end
  end

  // Datapath / registered-output next values
  always_comb begin
    exp_next      = exp_reg;
    match_next    = match_reg;
    miss_next     = miss_reg;
    err_next      = 1'b0;
    beat_cnt_next = beat_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    if (bus.valid_i) begin
      unique case (state_reg)
        SEEK: begin
          if (data_nz) begin
            exp_next   = step_dst[0];
            match_next = '0;
          end
        end
        ACQ: begin
          if (data_match) begin
            exp_next   = step_dst[1];
            match_next = match_reg + MatchW'(1);
            if (lock_hit) miss_next = '0;
          end else begin
            exp_next   = step_dst[0];
            match_next = '0;
          end
        end
        LOCKED: begin
          // Never reseed from the wire here, so a bad word cannot cascade.
          exp_next = step_dst[1];
          if (beat_cnt_reg != '1) beat_cnt_next = beat_cnt_reg + CntWidth'(1);
          if (data_match) begin
            miss_next = '0;
          end else begin
            err_next  = 1'b1;
            miss_next = miss_reg + MissW'(1);
            if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + CntWidth'(1);
          end
        end
        default: begin
          match_next = '0;
          miss_next  = '0;
        end
      endcase
    end
    if (bus.clr_i) begin
      beat_cnt_next = '0;
      err_cnt_next  = '0;
    end
  end

  assign bus.locked_o   = (state_reg == LOCKED);
  assign bus.err_o      = err_reg;
  assign bus.beat_cnt_o = beat_cnt_reg;
  assign bus.err_cnt_o  = err_cnt_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, error-in-lock, loss, zero words, gaps, reset,
// and counter clear/saturation on a second instance with narrow counters.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_a;
  logic        valid_b;
  logic        sel_b;
  logic [15:0] data;
  logic        clr;
  logic [15:0] cur;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_beats;

  always #5 clk = ~clk;

  prbs_checker_if #(.LfsrWidth(16), .CntWidth(16)) bus_a ();
  prbs_checker_if #(.LfsrWidth(16), .CntWidth(4))  bus_b ();

  assign bus_a.valid_i = valid_a;
  assign bus_a.data_i  = data;
  assign bus_a.clr_i   = clr;
  assign bus_b.valid_i = valid_b;
  assign bus_b.data_i  = data;
  assign bus_b.clr_i   = clr;

  prbs_checker #(
    .LfsrWidth(16), .Mask(16'h8679), .LockCount(4), .LossCount(4), .CntWidth(16)
  ) dut_a (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_a)
  );

  prbs_checker #(
    .LfsrWidth(16), .Mask(16'h8679), .LockCount(4), .LossCount(32), .CntWidth(4)
  ) dut_b (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_b)
  );

  function automatic logic [15:0] step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'h8679 : 16'h0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One beat: drive on a falling edge, sample at the next falling edge.
  task automatic beat(input logic [15:0] w, input logic c);
    @(negedge clk);
    if (sel_b) valid_b = 1'b1;
    else       valid_a = 1'b1;
    data = w;
    clr  = c;
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    clr     = 1'b0;
    $display("beat %s data=%h | A lock=%b err=%b beats=%0d errs=%0d | B lock=%b err=%b beats=%0d errs=%0d",
             sel_b ? "B" : "A", w, bus_a.locked_o, bus_a.err_o, bus_a.beat_cnt_o, bus_a.err_cnt_o,
             bus_b.locked_o, bus_b.err_o, bus_b.beat_cnt_o, bus_b.err_cnt_o);
  endtask

  task automatic good();
    beat(cur, 1'b0);
    cur = step(cur);
  endtask

  task automatic bad();
    beat(cur ^ 16'h0008, 1'b0);
    cur = step(cur);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    sel_b   = 1'b0;
    data    = '0;
    clr     = 1'b0;
    cur     = 16'hFFFF;

    repeat (3) @(negedge clk);
    check("rst_locked", bus_a.locked_o, 0);
    check("rst_err", bus_a.err_o, 0);
    check("rst_beats", bus_a.beat_cnt_o, 0);
    check("rst_errs", bus_a.err_cnt_o, 0);
    check("rst_errs_b", bus_b.err_cnt_o, 0);
    rst_n = 1'b1;

    // All-zero word while seeking is ignored
    beat(16'h0000, 1'b0);
    check("zero_seek_locked", bus_a.locked_o, 0);
    check("zero_seek_beats", bus_a.beat_cnt_o, 0);

    // Lock: FFFF seeds, then four matches; lock visible after the fifth beat
    repeat (4) good();
    check("lock_not_yet", bus_a.locked_o, 0);
    good();
    check("lock_locked", bus_a.locked_o, 1);
    check("lock_errs", bus_a.err_cnt_o, 0);
    check("lock_beats", bus_a.beat_cnt_o, 0);
    repeat (3) good();
    check("locked_beats3", bus_a.beat_cnt_o, 3);
    check("locked_no_err", bus_a.err_o, 0);

    // Single corrupted word while locked
    bad();
    check("err_pulse", bus_a.err_o, 1);
    check("err_cnt1", bus_a.err_cnt_o, 1);
    check("err_still_locked", bus_a.locked_o, 1);
    check("err_beats4", bus_a.beat_cnt_o, 4);
    good();
    check("err_pulse_end", bus_a.err_o, 0);
    check("err_cnt_hold", bus_a.err_cnt_o, 1);
    check("err_beats5", bus_a.beat_cnt_o, 5);

    // Random gaps in a correct stream
    exp_beats = 5;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        good();
        exp_beats++;
      end else begin
        @(negedge clk);
      end
    end
    check("gaps_errs", bus_a.err_cnt_o, 1);
    check("gaps_locked", bus_a.locked_o, 1);
    check("gaps_beats", bus_a.beat_cnt_o, exp_beats);

    // Clear without a beat
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_beats", bus_a.beat_cnt_o, 0);
    check("clr_errs", bus_a.err_cnt_o, 0);
    check("clr_locked", bus_a.locked_o, 1);

    // Loss of lock after four consecutive misses
    repeat (3) bad();
    check("loss_3_locked", bus_a.locked_o, 1);
    check("loss_3_errs", bus_a.err_cnt_o, 3);
    bad();
    check("loss_4_locked", bus_a.locked_o, 0);
    check("loss_4_errs", bus_a.err_cnt_o, 4);
    check("loss_4_beats", bus_a.beat_cnt_o, 4);
    repeat (4) good();
    check("relock_not_yet", bus_a.locked_o, 0);
    good();
    check("relock_locked", bus_a.locked_o, 1);
    check("relock_errs_kept", bus_a.err_cnt_o, 4);
    check("relock_beats_kept", bus_a.beat_cnt_o, 4);

    // Asynchronous reset while locked
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst2_locked", bus_a.locked_o, 0);
    check("rst2_beats", bus_a.beat_cnt_o, 0);
    check("rst2_errs", bus_a.err_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero word while acquiring sends the checker back to seeking
    good();
    beat(16'h0000, 1'b0);
    check("zero_acq_locked", bus_a.locked_o, 0);
    repeat (4) good();
    check("zero_acq_not_yet", bus_a.locked_o, 0);
    good();
    check("zero_acq_relock", bus_a.locked_o, 1);
    check("zero_acq_beats", bus_a.beat_cnt_o, 0);
    check("zero_acq_errs", bus_a.err_cnt_o, 0);

    // Narrow-counter instance: saturation and clear coincident with an error
    sel_b = 1'b1;
    repeat (5) good();
    check("b_locked", bus_b.locked_o, 1);
    repeat (14) bad();
    check("b_errs14", bus_b.err_cnt_o, 14);
    repeat (6) bad();
    check("b_errs_sat", bus_b.err_cnt_o, 15);
    check("b_beats_sat", bus_b.beat_cnt_o, 15);
    check("b_still_locked", bus_b.locked_o, 1);
    beat(cur ^ 16'h0008, 1'b1);
    cur = step(cur);
    check("b_clr_errs", bus_b.err_cnt_o, 0);
    check("b_clr_err_pulse", bus_b.err_o, 1);
    good();
    check("b_after_errs", bus_b.err_cnt_o, 0);
    check("b_after_beats", bus_b.beat_cnt_o, 1);
    check("b_after_err", bus_b.err_o, 0);
    check("a_hold_locked", bus_a.locked_o, 1);
    check("a_hold_beats", bus_a.beat_cnt_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
